// File: rtl/aes_core_arbiter_if.sv
`timescale 1ns/1ps
// aes_core_arbiter_if
// Byte-stream bundle between the two host channels, the arbiter and the AES core.
//   req0_* / req1_* : host -> arbiter plaintext/key bytes with valid/ready
//   rsp0_* / rsp1_* : arbiter -> host ciphertext beats (no backpressure)
//   aes_*           : arbiter <-> core byte stream and ciphertext return
// Modports:
//   slave  : the arbiter's view
//   master : the host/core side (used by the environment)
interface aes_core_arbiter_if;
    logic       req0_valid;
    logic [7:0] req0_pt;
    logic [7:0] req0_key;
    logic       req0_ready;
    logic       rsp0_valid;
    logic [7:0] rsp0_ct;

    logic       req1_valid;
    logic [7:0] req1_pt;
    logic [7:0] req1_key;
    logic       req1_ready;
    logic       rsp1_valid;
    logic [7:0] rsp1_ct;

    logic       aes_valid;
    logic [7:0] aes_pt;
    logic [7:0] aes_key;
    logic       aes_ready;
    logic       aes_ct_valid;
    logic [7:0] aes_ct;

    modport slave (
        input  req0_valid, req0_pt, req0_key,
        output req0_ready, rsp0_valid, rsp0_ct,
        input  req1_valid, req1_pt, req1_key,
        output req1_ready, rsp1_valid, rsp1_ct,
        output aes_valid, aes_pt, aes_key,
        input  aes_ready, aes_ct_valid, aes_ct
    );

    modport master (
        output req0_valid, req0_pt, req0_key,
        input  req0_ready, rsp0_valid, rsp0_ct,
        output req1_valid, req1_pt, req1_key,
        input  req1_ready, rsp1_valid, rsp1_ct,
        input  aes_valid, aes_pt, aes_key,
        output aes_ready, aes_ct_valid, aes_ct
    );
endinterface

// File: rtl/aes_core_arbiter.sv
`timescale 1ns/1ps
// aes_core_arbiter
// Shares one byte-serial AES-128 encrypt core between two requester channels.
// A channel owns the core for one whole 16-byte block (round-robin on ties);
// its PT/KEY bytes are passed straight through to the core and the returned
// ciphertext beats are registered onto that channel's response port.
// A watchdog abandons a block whose ciphertext stops arriving.
// Ports:
//   clk      : clock, rising edge
//   reset    : synchronous active-high reset
//   bus      : aes_core_arbiter_if.slave (request/response streams and core link)
//   grant    : owning channel, meaningful while busy = 1
//   busy     : a block is in progress
//   wdog_err : sticky watchdog error, cleared only by reset
module aes_core_arbiter #(
    parameter int BLOCK_BYTES = 16,
    parameter int WDOG_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    aes_core_arbiter_if.slave     bus,
    output logic                  grant,
    output logic                  busy,
    output logic                  wdog_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        WAIT_CT = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [3:0] LAST_BYTE  = 4'(BLOCK_BYTES - 1);
    localparam logic [7:0] WDOG_LIMIT = 8'(WDOG_CYCLES);

    state_t     state_r, state_s;
    logic [3:0] byte_cnt_r, byte_cnt_s;
    logic [7:0] wdog_cnt_r, wdog_cnt_s;
    logic       grant_r, grant_s;
    logic       rr_last_r, rr_last_s;
    logic       wdog_err_r, wdog_err_s;
    logic       busy_r;
    logic       rsp0_valid_r, rsp0_valid_s;
    logic       rsp1_valid_r, rsp1_valid_s;
    logic [7:0] rsp0_ct_r, rsp0_ct_s;
    logic [7:0] rsp1_ct_r, rsp1_ct_s;
    logic       req_valid_g_s;
    logic [7:0] req_pt_g_s;
    logic [7:0] req_key_g_s;

    // Next-state, counters and combinational handshake/pass-through outputs.
    always_comb begin
        state_s        = state_r;
        byte_cnt_s     = byte_cnt_r;
        wdog_cnt_s     = wdog_cnt_r;
        grant_s        = grant_r;
        rr_last_s      = rr_last_r;
        wdog_err_s     = wdog_err_r;
        rsp0_valid_s   = 1'b0;
        rsp1_valid_s   = 1'b0;
        rsp0_ct_s      = rsp0_ct_r;
        rsp1_ct_s      = rsp1_ct_r;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.aes_valid  = 1'b0;
        bus.aes_pt     = 8'h00;
        bus.aes_key    = 8'h00;

        // View of the owning channel's request stream.
        if (grant_r) begin
            req_valid_g_s = bus.req1_valid;
            req_pt_g_s    = bus.req1_pt;
            req_key_g_s   = bus.req1_key;
        end else begin
            req_valid_g_s = bus.req0_valid;
            req_pt_g_s    = bus.req0_pt;
            req_key_g_s   = bus.req0_key;
        end

        case (state_r)
            IDLE: begin
                if (bus.aes_ready && (bus.req0_valid || bus.req1_valid)) begin
                    // Sole requester wins; on a tie the channel that did not go last wins.
                    grant_s    = (bus.req0_valid && bus.req1_valid) ? ~rr_last_r : bus.req1_valid;
                    byte_cnt_s = 4'd0;
                    wdog_cnt_s = 8'd0;
                    state_s    = LOAD;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                bus.req0_ready = ~grant_r;
                bus.req1_ready = grant_r;
                bus.aes_valid  = req_valid_g_s;
                bus.aes_pt     = req_pt_g_s;
                bus.aes_key    = req_key_g_s;
                if (req_valid_g_s) begin
                    // Wraps to 0 on the last byte, ready to count CT beats.
                    byte_cnt_s = byte_cnt_r + 4'd1;
                    if (byte_cnt_r == LAST_BYTE) begin
                        wdog_cnt_s = 8'd0;
                        state_s    = WAIT_CT;
                    end else begin
                        state_s = LOAD;
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            WAIT_CT: begin
                if (bus.aes_ct_valid) begin
                    if (grant_r) begin
                        rsp1_valid_s = 1'b1;
                        rsp1_ct_s    = bus.aes_ct;
                    end else begin
                        rsp0_valid_s = 1'b1;
                        rsp0_ct_s    = bus.aes_ct;
                    end
                    wdog_cnt_s = 8'd0;
                    byte_cnt_s = byte_cnt_r + 4'd1;
                    if (byte_cnt_r == LAST_BYTE) begin
                        state_s = DONE;
                    end else begin
                        state_s = WAIT_CT;
                    end
                end else if (wdog_cnt_r == (WDOG_LIMIT - 8'd1)) begin
                    // This quiet cycle brings the count to the limit: abandon the block.
                    wdog_err_s = 1'b1;
                    rr_last_s  = grant_r;
                    byte_cnt_s = 4'd0;
                    wdog_cnt_s = 8'd0;
                    state_s    = IDLE;
                end else begin
                    wdog_cnt_s = wdog_cnt_r + 8'd1;
                end
            end
            DONE: begin
                if (bus.aes_ready) begin
                    rr_last_s = grant_r;
                    state_s   = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= IDLE;
            byte_cnt_r   <= 4'd0;
            wdog_cnt_r   <= 8'd0;
            grant_r      <= 1'b0;
            rr_last_r    <= 1'b1;
            wdog_err_r   <= 1'b0;
            busy_r       <= 1'b0;
            rsp0_valid_r <= 1'b0;
            rsp1_valid_r <= 1'b0;
            rsp0_ct_r    <= 8'h00;
            rsp1_ct_r    <= 8'h00;
        end else begin
            state_r      <= state_s;
            byte_cnt_r   <= byte_cnt_s;
            wdog_cnt_r   <= wdog_cnt_s;
            grant_r      <= grant_s;
            rr_last_r    <= rr_last_s;
            wdog_err_r   <= wdog_err_s;
            busy_r       <= (state_s != IDLE);
            rsp0_valid_r <= rsp0_valid_s;
            rsp1_valid_r <= rsp1_valid_s;
            rsp0_ct_r    <= rsp0_ct_s;
            rsp1_ct_r    <= rsp1_ct_s;
        end
    end

    assign grant          = grant_r;
    assign busy           = busy_r;
    assign wdog_err       = wdog_err_r;
    assign bus.rsp0_valid = rsp0_valid_r;
    assign bus.rsp0_ct    = rsp0_ct_r;
    assign bus.rsp1_valid = rsp1_valid_r;
    assign bus.rsp1_ct    = rsp1_ct_r;

endmodule

// File: tb/tb_aes_core_arbiter.sv
`timescale 1ns/1ps
// tb_aes_core_arbiter
// Drives two host channels and a behavioural stub core; checks routing,
// round-robin order, ciphertext delivery, watchdog timing and reset behaviour.
module tb_aes_core_arbiter;
    localparam int WDOG = 255;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic grant, busy, wdog_err;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    aes_core_arbiter_if bus();

    aes_core_arbiter #(.BLOCK_BYTES(16), .WDOG_CYCLES(WDOG)) dut (
        .clk(clk), .reset(reset), .bus(bus),
        .grant(grant), .busy(busy), .wdog_err(wdog_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Host-side drivers
    logic       drv_valid [2];
    logic [7:0] drv_pt [2];
    logic [7:0] drv_key [2];
    logic [127:0] tx_pt [2][4];
    logic [127:0] tx_key [2][4];
    assign bus.req0_valid = drv_valid[0];
    assign bus.req0_pt    = drv_pt[0];
    assign bus.req0_key   = drv_key[0];
    assign bus.req1_valid = drv_valid[1];
    assign bus.req1_pt    = drv_pt[1];
    assign bus.req1_key   = drv_key[1];

    // Stub core
    logic       stub_ready, stub_ct_valid, stray_valid;
    logic [7:0] stub_ct, stray_ct;
    int         stub_stop_after;
    int         stub_last_beat_edge = 0;
    int         core_bytes = 0;
    assign bus.aes_ready    = stub_ready;
    assign bus.aes_ct_valid = stub_ct_valid | stray_valid;
    assign bus.aes_ct       = stub_ct | stray_ct;

    // Stand-in cipher: the real AES-128 answer for the known vector, a keyed mix otherwise.
    function automatic logic [127:0] core_fn(input logic [127:0] pt, input logic [127:0] key);
        if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
        else return pt ^ {key[63:0], key[127:64]} ^ 128'hc3a5_5a3c_0ff0_f00f_1234_5678_9abc_def0;
    endfunction

    initial begin : core_stub
        logic [127:0] rx_pt, rx_key, ct;
        int n, beats, lim;
        rx_pt = '0; rx_key = '0;
        stub_ready = 1'b1; stub_ct_valid = 1'b0; stub_ct = 8'h00;
        forever begin
            n = 0;
            while (n < 16) begin
                @(negedge clk);
                if (reset) n = 0;
                else if (bus.aes_valid) begin
                    rx_pt  = {rx_pt[119:0], bus.aes_pt};
                    rx_key = {rx_key[119:0], bus.aes_key};
                    n++;
                    core_bytes++;
                end
            end
            ct = core_fn(rx_pt, rx_key);
            @(posedge clk); #1; stub_ready = 1'b0;
            repeat (2) begin @(posedge clk); #1; end
            beats = 0;
            lim = stub_stop_after;
            while (beats < lim && beats < 16) begin
                stub_ct_valid = 1'b1;
                stub_ct = ct[127-8*beats -: 8];
                stub_last_beat_edge = cyc + 1;
                beats++;
                @(posedge clk); #1;
                stub_ct_valid = 1'b0; stub_ct = 8'h00;
                repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            end
            if (beats < 16) begin
                n = 0;
                while (n < 1000) begin @(negedge clk); if (!busy) break; n++; end
                @(posedge clk); #1;
            end else begin
                repeat (2) begin @(posedge clk); #1; end
            end
            stub_ready = 1'b1;
        end
    end

    // Response / grant monitor
    logic [7:0] rsp_q0[$];
    logic [7:0] rsp_q1[$];
    int         grant_q[$];
    logic       busy_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) busy_prev <= 1'b0;
        else begin
            if (bus.rsp0_valid) rsp_q0.push_back(bus.rsp0_ct);
            if (bus.rsp1_valid) rsp_q1.push_back(bus.rsp1_ct);
            if (busy && !busy_prev) grant_q.push_back(int'(grant));
            busy_prev <= busy;
        end
    end

    function automatic logic [7:0] q_byte(input int ch, input int idx);
        if (ch == 0) return (idx < rsp_q0.size()) ? rsp_q0[idx] : 8'hxx;
        else return (idx < rsp_q1.size()) ? rsp_q1[idx] : 8'hxx;
    endfunction

    function automatic int q_size(input int ch);
        return (ch == 0) ? rsp_q0.size() : rsp_q1.size();
    endfunction

    task automatic set_byte(input int ch, input int i);
        drv_valid[ch] = 1'b1;
        drv_pt[ch]    = tx_pt[ch][i/16][127-8*(i%16) -: 8];
        drv_key[ch]   = tx_key[ch][i/16][127-8*(i%16) -: 8];
    endtask

    task automatic rand_blocks(input int ch);
        for (int b = 0; b < 4; b++) begin
            tx_pt[ch][b]  = {$urandom, $urandom, $urandom, $urandom};
            tx_key[ch][b] = {$urandom, $urandom, $urandom, $urandom};
        end
    endtask

    // Streams nbytes from tx_pt/tx_key of channel ch; optional gap after gap_after accepted bytes.
    task automatic send(input int ch, input int nbytes, input int gap_after, input int gap_len);
        int i = 0;
        int budget = 4000;
        bit acc;
        set_byte(ch, 0);
        while (i < nbytes && budget > 0) begin
            @(negedge clk);
            acc = (ch == 0) ? bus.req0_ready : bus.req1_ready;
            budget--;
            @(posedge clk); #1;
            if (acc) begin
                i++;
                if (i == gap_after) begin
                    drv_valid[ch] = 1'b0;
                    repeat (gap_len) begin @(posedge clk); #1; end
                end
                if (i < nbytes) set_byte(ch, i);
                else drv_valid[ch] = 1'b0;
            end
        end
        drv_valid[ch] = 1'b0;
        checks++;
        if (i !== nbytes) begin
            errors++;
            $display("FAIL send_ch%0d: accepted %0d bytes, required %0d", ch, i, nbytes);
        end
    endtask

    task automatic wait_rsp(input int ch, input int target);
        int budget = 3000;
        while (q_size(ch) < target && budget > 0) begin @(negedge clk); budget--; end
        @(posedge clk); #1;
    endtask

    task automatic wait_idle();
        int budget = 1000;
        do begin @(negedge clk); budget--; end while ((busy || !stub_ready) && budget > 0);
        checks++;
        if (busy || !stub_ready) begin
            errors++;
            $display("FAIL wait_idle: busy=%0b core_ready=%0b, required 0/1", busy, stub_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic apply_reset();
        drv_valid[0] = 1'b0; drv_valid[1] = 1'b0;
        reset = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drv_valid[0] = 1'b1; drv_pt[0] = 8'h5a; drv_key[0] = 8'ha5;
        drv_valid[1] = 1'b1; drv_pt[1] = 8'h3c; drv_key[1] = 8'hc3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if ({grant, busy, wdog_err} !== 3'b000) begin errors++; $display("FAIL reset_status: grant/busy/wdog=%b, required 000", {grant, busy, wdog_err}); end
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready: %b, required 00", {bus.req0_ready, bus.req1_ready}); end
        checks++; if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid: %b, required 00", {bus.rsp0_valid, bus.rsp1_valid}); end
        checks++; if ({bus.rsp0_ct, bus.rsp1_ct} !== 16'h0000) begin errors++; $display("FAIL reset_rsp_ct: %h, required 0000", {bus.rsp0_ct, bus.rsp1_ct}); end
        checks++; if ({bus.aes_valid, bus.aes_pt, bus.aes_key} !== 17'h0) begin errors++; $display("FAIL reset_aes: %h, required 0", {bus.aes_valid, bus.aes_pt, bus.aes_key}); end
        @(posedge clk); #1;
        drv_valid[0] = 1'b0; drv_valid[1] = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single_ch0();
        int b0, b1, gb;
        logic [127:0] exp;
        apply_reset();
        tx_pt[0][0] = FIPS_PT; tx_key[0][0] = FIPS_KEY;
        b0 = rsp_q0.size(); b1 = rsp_q1.size(); gb = grant_q.size();
        send(0, 16, 0, 0);
        wait_rsp(0, b0 + 16);
        wait_idle();
        exp = FIPS_CT;
        for (int b = 0; b < 16; b++) begin
            checks++;
            if (q_byte(0, b0 + b) !== exp[127-8*b -: 8]) begin errors++; $display("FAIL fips_ct[%0d]: got %h, required %h", b, q_byte(0, b0 + b), exp[127-8*b -: 8]); end
        end
        checks++; if (rsp_q0.size() - b0 !== 16) begin errors++; $display("FAIL fips_beats: got %0d, required 16", rsp_q0.size() - b0); end
        checks++; if (rsp_q1.size() !== b1) begin errors++; $display("FAIL fips_rsp1_quiet: got %0d beats, required 0", rsp_q1.size() - b1); end
        checks++; if (grant_q.size() !== gb + 1 || q_grant(gb) !== 0) begin errors++; $display("FAIL fips_grant: got %0d grants first=%0d, required 1 grant to ch0", grant_q.size() - gb, q_grant(gb)); end
    endtask

    function automatic int q_grant(input int idx);
        return (idx < grant_q.size()) ? grant_q[idx] : -1;
    endfunction

    task automatic test_tie();
        int bs [2];
        int gb, last;
        int rem [2];
        int exp_g [4];
        logic [127:0] exp;
        apply_reset();
        rand_blocks(0); rand_blocks(1);
        bs[0] = rsp_q0.size(); bs[1] = rsp_q1.size(); gb = grant_q.size();
        // Both channels pending throughout: round-robin from the reset preference (ch0 first).
        last = 1; rem[0] = 2; rem[1] = 2;
        for (int k = 0; k < 4; k++) begin
            if (rem[0] > 0 && rem[1] > 0) exp_g[k] = 1 - last;
            else exp_g[k] = (rem[0] > 0) ? 0 : 1;
            rem[exp_g[k]]--;
            last = exp_g[k];
        end
        fork
            send(0, 32, 0, 0);
            send(1, 32, 0, 0);
        join
        wait_rsp(0, bs[0] + 32);
        wait_rsp(1, bs[1] + 32);
        wait_idle();
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (q_grant(gb + k) !== exp_g[k]) begin errors++; $display("FAIL tie_grant[%0d]: got %0d, required %0d", k, q_grant(gb + k), exp_g[k]); end
        end
        for (int ch = 0; ch < 2; ch++) begin
            for (int blk = 0; blk < 2; blk++) begin
                exp = core_fn(tx_pt[ch][blk], tx_key[ch][blk]);
                for (int b = 0; b < 16; b++) begin
                    checks++;
                    if (q_byte(ch, bs[ch] + 16*blk + b) !== exp[127-8*b -: 8]) begin errors++; $display("FAIL tie_ct ch%0d blk%0d byte%0d: got %h, required %h", ch, blk, b, q_byte(ch, bs[ch] + 16*blk + b), exp[127-8*b -: 8]); end
                end
            end
        end
    endtask

    task automatic test_gap();
        int b0, b1, gb, cb;
        logic [127:0] exp;
        apply_reset();
        rand_blocks(0); rand_blocks(1);
        b0 = rsp_q0.size(); b1 = rsp_q1.size(); gb = grant_q.size(); cb = core_bytes;
        fork
            send(1, 16, 7, 5);
            begin repeat (3) begin @(posedge clk); #1; end send(0, 16, 0, 0); end
            begin
                wait_rsp(1, b1 + 16);
                checks++; if (core_bytes - cb !== 16) begin errors++; $display("FAIL gap_core_bytes: got %0d, required 16", core_bytes - cb); end
                checks++; if (grant_q.size() !== gb + 1 || rsp_q0.size() !== b0) begin errors++; $display("FAIL gap_ch0_waits: grants %0d ch0 beats %0d, required 1 and 0", grant_q.size() - gb, rsp_q0.size() - b0); end
            end
        join
        wait_rsp(0, b0 + 16);
        wait_idle();
        checks++; if (q_grant(gb) !== 1 || q_grant(gb + 1) !== 0) begin errors++; $display("FAIL gap_order: got %0d,%0d, required 1,0", q_grant(gb), q_grant(gb + 1)); end
        for (int ch = 0; ch < 2; ch++) begin
            exp = core_fn(tx_pt[ch][0], tx_key[ch][0]);
            for (int b = 0; b < 16; b++) begin
                checks++;
                if (q_byte(ch, ((ch == 0) ? b0 : b1) + b) !== exp[127-8*b -: 8]) begin errors++; $display("FAIL gap_ct ch%0d byte%0d: got %h, required %h", ch, b, q_byte(ch, ((ch == 0) ? b0 : b1) + b), exp[127-8*b -: 8]); end
            end
        end
    endtask

    task automatic test_watchdog();
        int b0, b1, gb, err_edge, budget;
        logic busy_at_err;
        logic [127:0] exp;
        apply_reset();
        rand_blocks(0); rand_blocks(1);
        b0 = rsp_q0.size(); b1 = rsp_q1.size();
        stub_stop_after = 3;
        send(0, 16, 0, 0);
        err_edge = -1; busy_at_err = 1'bx; budget = 2000;
        while (budget > 0) begin
            @(negedge clk);
            if (wdog_err) begin err_edge = cyc; busy_at_err = busy; break; end
            budget--;
        end
        stub_stop_after = 16;
        checks++; if (err_edge !== stub_last_beat_edge + WDOG) begin errors++; $display("FAIL wdog_timing: error at edge %0d, required %0d", err_edge, stub_last_beat_edge + WDOG); end
        checks++; if (busy_at_err !== 1'b0) begin errors++; $display("FAIL wdog_idle: busy=%b, required 0", busy_at_err); end
        wait_idle();
        checks++; if (rsp_q0.size() - b0 !== 3) begin errors++; $display("FAIL wdog_beats: got %0d, required 3", rsp_q0.size() - b0); end
        exp = core_fn(tx_pt[0][0], tx_key[0][0]);
        for (int b = 0; b < 3; b++) begin
            checks++;
            if (q_byte(0, b0 + b) !== exp[127-8*b -: 8]) begin errors++; $display("FAIL wdog_ct[%0d]: got %h, required %h", b, q_byte(0, b0 + b), exp[127-8*b -: 8]); end
        end
        gb = grant_q.size();
        send(1, 16, 0, 0);
        wait_rsp(1, b1 + 16);
        wait_idle();
        exp = core_fn(tx_pt[1][0], tx_key[1][0]);
        checks++; if (q_grant(gb) !== 1) begin errors++; $display("FAIL wdog_next_grant: got %0d, required 1", q_grant(gb)); end
        checks++; if (wdog_err !== 1'b1) begin errors++; $display("FAIL wdog_sticky: got %b, required 1", wdog_err); end
        for (int b = 0; b < 16; b++) begin
            checks++;
            if (q_byte(1, b1 + b) !== exp[127-8*b -: 8]) begin errors++; $display("FAIL wdog_after_ct[%0d]: got %h, required %h", b, q_byte(1, b1 + b), exp[127-8*b -: 8]); end
        end
    endtask

    task automatic test_reset_mid();
        int b1;
        logic [127:0] exp;
        rand_blocks(1);
        send(1, 9, 0, 0);
        checks++; if ({busy, grant} !== 2'b11) begin errors++; $display("FAIL mid_loading: busy/grant=%b, required 11", {busy, grant}); end
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if ({busy, grant, wdog_err} !== 3'b000) begin errors++; $display("FAIL mid_reset_status: busy/grant/wdog=%b, required 000", {busy, grant, wdog_err}); end
        checks++; if ({bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_ct, bus.rsp1_ct} !== 18'h0) begin errors++; $display("FAIL mid_reset_rsp: %h, required 0", {bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_ct, bus.rsp1_ct}); end
        checks++; if ({bus.req1_ready, bus.aes_valid, bus.aes_pt, bus.aes_key} !== 18'h0) begin errors++; $display("FAIL mid_reset_aes: %h, required 0", {bus.req1_ready, bus.aes_valid, bus.aes_pt, bus.aes_key}); end
        reset = 1'b0;
        rand_blocks(1);
        b1 = rsp_q1.size();
        send(1, 16, 0, 0);
        wait_rsp(1, b1 + 16);
        wait_idle();
        exp = core_fn(tx_pt[1][0], tx_key[1][0]);
        for (int b = 0; b < 16; b++) begin
            checks++;
            if (q_byte(1, b1 + b) !== exp[127-8*b -: 8]) begin errors++; $display("FAIL mid_fresh_ct[%0d]: got %h, required %h", b, q_byte(1, b1 + b), exp[127-8*b -: 8]); end
        end
    endtask

    task automatic test_stray();
        int b0, b1;
        logic [127:0] exp;
        rand_blocks(0);
        b0 = rsp_q0.size(); b1 = rsp_q1.size();
        stray_valid = 1'b1; stray_ct = 8'ha5;
        @(posedge clk); #1;
        stray_valid = 1'b0; stray_ct = 8'h00;
        @(negedge clk);
        checks++; if ({bus.rsp0_valid, bus.rsp1_valid, busy} !== 3'b000) begin errors++; $display("FAIL stray_rsp: rsp0/rsp1/busy=%b, required 000", {bus.rsp0_valid, bus.rsp1_valid, busy}); end
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        checks++; if (rsp_q0.size() !== b0 || rsp_q1.size() !== b1) begin errors++; $display("FAIL stray_beats: got %0d/%0d, required 0/0", rsp_q0.size() - b0, rsp_q1.size() - b1); end
        send(0, 16, 0, 0);
        wait_rsp(0, b0 + 16);
        wait_idle();
        exp = core_fn(tx_pt[0][0], tx_key[0][0]);
        for (int b = 0; b < 16; b++) begin
            checks++;
            if (q_byte(0, b0 + b) !== exp[127-8*b -: 8]) begin errors++; $display("FAIL stray_after_ct[%0d]: got %h, required %h", b, q_byte(0, b0 + b), exp[127-8*b -: 8]); end
        end
    endtask

    initial begin
        drv_valid[0] = 1'b0; drv_valid[1] = 1'b0;
        drv_pt[0] = 8'h00; drv_pt[1] = 8'h00; drv_key[0] = 8'h00; drv_key[1] = 8'h00;
        stray_valid = 1'b0; stray_ct = 8'h00;
        stub_stop_after = 16;
        reset = 1'b1;
        test_reset();
        test_single_ch0();
        test_tie();
        test_gap();
        test_watchdog();
        test_reset_mid();
        test_stray();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
